// File: rtl/reaction_session_ctrl_if.sv
// Session-control bundle shared by the reaction controller, its host and the
// reaction timer. The master side drives requests and the timer feedback; the
// slave side (the controller) drives the timer start pulse and the results.
interface reaction_session_ctrl_if;
   logic        iSTART_REQ;
   logic        iABORT;
   logic [1:0]  iTIMER_STATE;
   logic [13:0] iTIMER_FINAL;
   logic        oTIMER_START;
   logic [2:0]  oROUND;
   logic [13:0] oBEST;
   logic [13:0] oAVG;
   logic        oBUSY;
   logic        oSESSION_DONE;

   modport master (
      output iSTART_REQ, iABORT, iTIMER_STATE, iTIMER_FINAL,
      input  oTIMER_START, oROUND, oBEST, oAVG, oBUSY, oSESSION_DONE
   );

   modport slave (
      input  iSTART_REQ, iABORT, iTIMER_STATE, iTIMER_FINAL,
      output oTIMER_START, oROUND, oBEST, oAVG, oBUSY, oSESSION_DONE
   );
endinterface

// File: rtl/reaction_session_ctrl.sv
// Reaction session controller: runs ROUNDS timer rounds separated by
// GAP_CYCLES idle cycles, tracks the best result and the floor average.
// Optional macro REACTION_FALSE_START_RETRY_EN: a 9999 result (false start or
// timeout) is discarded and the same round is retried after the gap.
module reaction_session_ctrl #(
   parameter int unsigned ROUNDS     = 5,
   parameter int unsigned GAP_CYCLES = 25_000_000
) (
   input logic                    iCLK,
   input logic                    iRST_N,
   reaction_session_ctrl_if.slave bus
);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] PREP      = 4'd1;
   localparam logic [3:0] KICK      = 4'd2;
   localparam logic [3:0] WAIT_DONE = 4'd3;
   localparam logic [3:0] SETTLE    = 4'd4;
   localparam logic [3:0] LATCH     = 4'd5;
   localparam logic [3:0] GAP       = 4'd6;
   localparam logic [3:0] DIVIDE    = 4'd7;
   localparam logic [3:0] DONE      = 4'd8;

   localparam logic [13:0] NO_RESULT  = 14'd9999;
   localparam logic [2:0]  LAST_ROUND = 3'(ROUNDS - 1);
   localparam logic [2:0]  DIVISOR    = 3'(ROUNDS);
   localparam logic [25:0] GAP_LAST   = 26'(GAP_CYCLES - 1);
   localparam logic [4:0]  DIV_LAST   = 5'd16;

   logic [3:0]  state_q, state_d;
   logic        startPrev_q;
   logic        timerStart_q, timerStart_d;
   logic        clearSent_q, clearSent_d;
   logic [2:0]  round_q, round_d;
   logic [13:0] best_q, best_d;
   logic [13:0] avg_q, avg_d;
   logic [16:0] sum_q, sum_d;
   logic [25:0] gapCnt_q, gapCnt_d;
   logic [16:0] quot_q, quot_d;
   logic [2:0]  rem_q, rem_d;
   logic [4:0]  divCnt_q, divCnt_d;

   logic        startEdge;
   logic        countSample;
   logic [16:0] sumNext;
   logic [3:0]  remShift;

   assign startEdge = bus.iSTART_REQ & ~startPrev_q;
   assign sumNext   = sum_q + {3'b000, bus.iTIMER_FINAL};
   assign remShift  = {rem_q, quot_q[16]};

`ifdef REACTION_FALSE_START_RETRY_EN
   assign countSample = (bus.iTIMER_FINAL != NO_RESULT);
`else
   assign countSample = 1'b1;
`endif

   // Next-state and datapath decisions for the whole session sequence.
   always_comb begin
      state_d      = state_q;
      timerStart_d = 1'b0;
      clearSent_d  = clearSent_q;
      round_d      = round_q;
      best_d       = best_q;
      avg_d        = avg_q;
      sum_d        = sum_q;
      gapCnt_d     = gapCnt_q;
      quot_d       = quot_q;
      rem_d        = rem_q;
      divCnt_d     = divCnt_q;

      if (bus.iABORT && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (startEdge && !bus.iABORT) begin
                  sum_d       = 17'd0;
                  round_d     = 3'd0;
                  best_d      = NO_RESULT;
                  avg_d       = 14'd0;
                  clearSent_d = 1'b0;
                  state_d     = PREP;
               end
            end
            PREP: begin
               case (bus.iTIMER_STATE)
                  2'd0: begin
                     timerStart_d = 1'b1;
                     state_d      = KICK;
                  end
                  2'd3: begin
                     if (!clearSent_q) begin
                        timerStart_d = 1'b1;
                        clearSent_d  = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            KICK: begin
               state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.iTIMER_STATE == 2'd3) begin
                  state_d = SETTLE;
               end
            end
            SETTLE: begin
               state_d = LATCH;
            end
            LATCH: begin
               gapCnt_d = 26'd0;
               state_d  = GAP;
               if (countSample) begin
                  sum_d = sumNext;
                  if (bus.iTIMER_FINAL < best_q) begin
                     best_d = bus.iTIMER_FINAL;
                  end
                  if (round_q == LAST_ROUND) begin
                     quot_d   = sumNext;
                     rem_d    = 3'd0;
                     divCnt_d = 5'd0;
                     state_d  = DIVIDE;
                  end else begin
                     round_d = round_q + 3'd1;
                  end
               end
            end
            GAP: begin
               if (gapCnt_q == GAP_LAST) begin
                  clearSent_d = 1'b0;
                  state_d     = PREP;
               end else begin
                  gapCnt_d = gapCnt_q + 26'd1;
               end
            end
            DIVIDE: begin
               if (remShift >= {1'b0, DIVISOR}) begin
                  rem_d  = remShift[2:0] - DIVISOR;
                  quot_d = {quot_q[15:0], 1'b1};
               end else begin
                  rem_d  = remShift[2:0];
                  quot_d = {quot_q[15:0], 1'b0};
               end
               divCnt_d = divCnt_q + 5'd1;
               if (divCnt_q == DIV_LAST) begin
                  avg_d   = quot_d[13:0];
                  state_d = DONE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State registers; the edge detector resets high so a held request is not a start.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q      <= IDLE;
         startPrev_q  <= 1'b1;
         timerStart_q <= 1'b0;
         clearSent_q  <= 1'b0;
         round_q      <= 3'd0;
         best_q       <= NO_RESULT;
         avg_q        <= 14'd0;
         sum_q        <= 17'd0;
         gapCnt_q     <= 26'd0;
         quot_q       <= 17'd0;
         rem_q        <= 3'd0;
         divCnt_q     <= 5'd0;
      end else begin
         state_q      <= state_d;
         startPrev_q  <= bus.iSTART_REQ;
         timerStart_q <= timerStart_d;
         clearSent_q  <= clearSent_d;
         round_q      <= round_d;
         best_q       <= best_d;
         avg_q        <= avg_d;
         sum_q        <= sum_d;
         gapCnt_q     <= gapCnt_d;
         quot_q       <= quot_d;
         rem_q        <= rem_d;
         divCnt_q     <= divCnt_d;
      end
   end

   assign bus.oTIMER_START  = timerStart_q;
   assign bus.oROUND        = round_q;
   assign bus.oBEST         = best_q;
   assign bus.oAVG          = avg_q;
   assign bus.oBUSY         = (state_q != IDLE) && (state_q != DONE);
   assign bus.oSESSION_DONE = (state_q == DONE);

endmodule
